// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared definitions for the two-requester ROM read arbiter: ROM geometry and
// the read FSM state encoding.
// -----------------------------------------------------------------------------
package rom_arb_pkg;

  localparam int ROM_AW = 4;   // ROM word address width
  localparam int ROM_DW = 16;  // ROM data width

  // One read in flight at a time: accept, let the ROM sample, capture, respond.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

endpackage : rom_arb_pkg

// File: rtl/rom_arb_rr.sv
// -----------------------------------------------------------------------------
// rom_arb_rr
// Two-input combinational winner select for the ROM read arbiter.
//
// Configuration macro: ROM_ARB_RR_EN
//   defined   : round-robin; on a tie the requester not granted last wins.
//   undefined : fixed priority; requester 0 wins every tie, no last_grant port.
//
// Ports
//   winner     out  selected requester (0 when nothing is valid)
//   valid0/1   in   requester has a read pending
//   last_grant in   requester granted most recently (ROM_ARB_RR_EN only)
// -----------------------------------------------------------------------------
module rom_arb_rr (
  output logic winner,
  input  logic valid0,
  input  logic valid1
`ifdef ROM_ARB_RR_EN
  ,
  input  logic last_grant
`endif
);

  always_comb begin
`ifdef ROM_ARB_RR_EN
    // A lone requester always wins; a tie goes to whoever was not served last.
    if (valid0 && valid1) winner = ~last_grant;
    else                  winner = valid1;
`else
    winner = valid1 & ~valid0;
`endif
  end

endmodule : rom_arb_rr

// File: rtl/rom_read_arb.sv
// -----------------------------------------------------------------------------
// rom_read_arb
// Arbitrates two read requesters onto one synchronous ROM (registered address,
// data returned one cycle after sampling). Exactly one read is outstanding; a
// read takes four cycles minimum: accept, ISSUE, CAPTURE, RESP.
//
// Configuration macro: ROM_ARB_RR_EN (round-robin when defined, fixed priority
// toward requester 0 otherwise).
//
// Ports
//   CLK                  clock, rising edge
//   RST                  asynchronous active-low reset
//   req0/1_valid, _adr   read requests
//   req0/1_ready         request accepted when ready & valid (IDLE only)
//   rom_adr, rom_d       ROM address (registered) and ROM data
//   rsp_valid/id/data    response, held until rsp_ready
//   rsp_ready            response consumer ready
//   busy                 FSM not in IDLE
// -----------------------------------------------------------------------------
module rom_read_arb
  import rom_arb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  input  logic [ROM_AW-1:0] req0_adr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ROM_AW-1:0] req1_adr,
  output logic              req1_ready,
  output logic [ROM_AW-1:0] rom_adr,
  input  logic [ROM_DW-1:0] rom_d,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [ROM_DW-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy
);

  state_t state, next_state;
  logic   winner;
  logic   accept;

`ifdef ROM_ARB_RR_EN
  logic last_grant;

  rom_arb_rr u_arb (
    .winner     (winner),
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant)
  );

  // Starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                        last_grant <= 1'b1;
    else if (state == IDLE && accept) last_grant <= winner;
  end
`else
  rom_arb_rr u_arb (
    .winner (winner),
    .valid0 (req0_valid),
    .valid1 (req1_valid)
  );
`endif

  // Ready depends only on state and winner, never on the requester's own
  // valid beyond arbitration, so at most one ready is high per cycle.
  assign req0_ready = (state == IDLE) && !winner;
  assign req1_ready = (state == IDLE) &&  winner;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath. Reset mid-read clears rsp_valid and returns to IDLE, so the
  // discarded read can never surface as a response.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rom_adr   <= '0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rom_adr <= winner ? req1_adr : req0_adr;
            rsp_id  <= winner;
          end
        end
        CAPTURE: begin
          // ROM sampled rom_adr on the ISSUE->CAPTURE edge; its D is valid now.
          rsp_data  <= rom_d;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : rom_read_arb

// File: tb/tb_rom_read_arb.sv
// -----------------------------------------------------------------------------
// tb_rom_read_arb
// Directed bench for rom_read_arb with a registered-output ROM model and a
// response scoreboard. Honours ROM_ARB_RR_EN for the tie-break expectation.
// -----------------------------------------------------------------------------
module tb_rom_read_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_adr, req1_adr;
  logic        req0_ready, req1_ready;
  logic [3:0]  rom_adr;
  logic [15:0] rom_d;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] rom [16];
  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;

  rom_read_arb dut (
    .CLK        (CLK),
    .RST        (RST),
    .req0_valid (req0_valid),
    .req0_adr   (req0_adr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_adr   (req1_adr),
    .req1_ready (req1_ready),
    .rom_adr    (rom_adr),
    .rom_d      (rom_d),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // Synchronous ROM: D is registered one cycle after ADR is sampled.
  always @(posedge CLK) rom_d <= rom[rom_adr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Scoreboard consumer: a response completes on the edge following a
  // negedge where rsp_valid & rsp_ready are both high.
  always @(negedge CLK) begin
    if (RST === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
        check("rsp_data", {16'd0, rsp_data}, {16'd0, mon_e.data});
      end
    end
  end

  // Starts and ends at posedge+1; returns cycle stamp of the last accept.
  task automatic wait_accepts(input int n, output int cyc);
    int seen = 0;
    cyc = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge CLK);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        seen++;
        cyc = cycle;
      end
      @(posedge CLK);
      #1;
    end
    check("accept_count", seen, n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(posedge CLK);
      #1;
    end
    check("sb_drained", sb.size(), 0);
    check("idle_after_drain", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c, prev;

    for (int i = 0; i < 16; i++) rom[i] = {4'ha, i[3:0], ~i[3:0], i[3:0]};
    rom[2]  = 16'h2222;
    rom[3]  = 16'h0412;
    rom[4]  = 16'h4839;
    rom[8]  = 16'hcafe;
    rom[9]  = 16'h6225;
    rom[15] = 16'h5555;

    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_adr = 4'h0;   req1_adr = 4'h0;
    rsp_ready = 1'b1;

    // Reset values
    #12;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rom_adr", {28'd0, rom_adr}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Tie: both requesters held valid for three reads
    sb.push_back('{id: 1'b0, data: 16'hcafe});
`ifdef ROM_ARB_RR_EN
    sb.push_back('{id: 1'b1, data: 16'h6225});
`else
    sb.push_back('{id: 1'b0, data: 16'hcafe});
`endif
    sb.push_back('{id: 1'b0, data: 16'hcafe});
    req0_adr = 4'h8; req1_adr = 4'h9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_accepts(3, c);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // Single read from requester 0, exact latency
    req0_adr = 4'h3; req0_valid = 1'b1;
    @(negedge CLK);
    check("r0_ready_same_cycle", {31'd0, req0_ready}, 32'd1);
    check("r1_ready_low", {31'd0, req1_ready}, 32'd0);
    sb.push_back('{id: 1'b0, data: 16'h0412});
    @(posedge CLK); #1;          // accept edge
    req0_valid = 1'b0;
    req0_adr = 4'hf;             // ignored outside the accept cycle
    @(negedge CLK);
    check("issue_rom_adr", {28'd0, rom_adr}, 32'd3);
    check("issue_busy", {31'd0, busy}, 32'd1);
    check("issue_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("issue_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    check("capture_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    check("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("resp_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("resp_rsp_data", {16'd0, rsp_data}, 32'h0412);
    @(negedge CLK);
    check("after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("after_rsp_busy", {31'd0, busy}, 32'd0);
    check("rom_adr_held", {28'd0, rom_adr}, 32'd3);
    @(posedge CLK); #1;

    // Backpressure: rsp_ready low for 5 cycles in RESP
    rsp_ready = 1'b0;
    req0_adr = 4'hf; req0_valid = 1'b1;
    sb.push_back('{id: 1'b0, data: 16'h5555});
    wait_accepts(1, c);
    req0_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;          // now in RESP
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_data", {16'd0, rsp_data}, 32'h5555);
      check("stall_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("stall_busy", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
    end
    rsp_ready = 1'b1;
    wait_drain();

    // Reset during CAPTURE discards the read
    req0_adr = 4'h2; req0_valid = 1'b1;
    wait_accepts(1, c);
    req0_valid = 1'b0;
    @(posedge CLK); #2;          // in CAPTURE
    RST = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rom_adr", {28'd0, rom_adr}, 32'd0);
    check("midrst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("midrst_rsp_id", {31'd0, rsp_id}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) prev++;
      @(posedge CLK); #1;
    end
    check("no_rsp_after_rst", prev, 0);
    req0_adr = 4'h4; req0_valid = 1'b1;
    sb.push_back('{id: 1'b0, data: 16'h4839});
    wait_accepts(1, c);
    req0_valid = 1'b0;
    wait_drain();

    // Back-to-back sweep from requester 1
    prev = 0;
    req1_valid = 1'b1;
    for (int a = 0; a < 16; a++) begin
      req1_adr = a[3:0];
      sb.push_back('{id: 1'b1, data: rom[a]});
      wait_accepts(1, c);
      if (a > 0) check("sweep_period", c - prev, 4);
      prev = c;
    end
    req1_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rom_read_arb
